// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared constants for the data-memory arbiter. These are the
//                FSM state encodings, the access width codes and the
//                illegal-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef DATA_MEM_WIDTH
`define DATA_MEM_WIDTH 10
`endif

package dmem_arbiter_pkg;

    // Memory geometry defaults. An enclosing build may override them through
    // the project-wide DATA_WIDTH / DATA_MEM_WIDTH macros.
    localparam int c_DATA_WIDTH     = `DATA_WIDTH;
    localparam int c_DATA_MEM_WIDTH = `DATA_MEM_WIDTH;

    // Sequencer states
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    // Access width codes
    localparam logic [2:0] c_W8  = 3'd0;
    localparam logic [2:0] c_W16 = 3'd1;
    localparam logic [2:0] c_W32 = 3'd2;
    localparam logic [2:0] c_W64 = 3'd3;

    // Codes above 64-bit are not supported by the memory
    function automatic logic width_illegal(input logic [2:0] w);
        return (w > c_W64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Two-requester grant picker. It supports round-robin or fixed
//                priority, plus a force override that lets a locked owner keep
//                the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       fixed_prio,
    input  logic       force_en,
    input  logic       force_id,
    output logic [1:0] grant
);

    // Force wins if its port is asking; otherwise a single requester wins and
    // a tie goes to port 0 (fixed) or to the port that did not win last time.
    always_comb begin
        grant = 2'b00;
        if (force_en && req[force_id]) begin
            grant = force_id ? 2'b10 : 2'b01;
        end else if (req == 2'b11) begin
            if (fixed_prio || last_owner) grant = 2'b01;
            else                          grant = 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter/sequencer for the shared data memory.
//                Port 0 is the CPU load/store stage and port 1 is the
//                DMA/debug master. Each access runs IDLE -> ACCESS -> RESP.
//                The memory is driven for the single ACCESS cycle, and a
//                registered done/rdata/err is returned to the owner in RESP.
//  Config      : DMEM_ARB_LOCK_EN - when defined, lock[owner] sampled in RESP
//                lets the owner win the next IDLE arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = c_DATA_MEM_WIDTH,
    parameter int DW         = c_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [2:0]    width0,
    input  logic [2:0]    width1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    lock,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [2:0]    mem_width,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic c_FIXED = (FIXED_PRIO != 0);

    logic [1:0] r_state;
    logic       r_owner;
    logic       r_last_owner;
    logic       r_we_l;
    logic       r_illegal;
    logic       w_force_en;
    logic [1:0] w_grant;
    logic       w_win;
    logic       w_sel_we;
    logic       w_sel_ill;
    logic [2:0] w_sel_width;

`ifdef DMEM_ARB_LOCK_EN
    logic r_locked;
    assign w_force_en = r_locked;
`else
    // lock has no function in this build
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
    assign w_force_en    = 1'b0;
`endif

    rr_pick2 u_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .fixed_prio (c_FIXED),
        .force_en   (w_force_en),
        .force_id   (r_owner),
        .grant      (w_grant)
    );

    assign w_win       = w_grant[1];
    assign w_sel_we    = w_win ? we[1]  : we[0];
    assign w_sel_width = w_win ? width1 : width0;
    assign w_sel_ill   = width_illegal(w_sel_width);

    // Sequencer: the mem_* registers double as the command latch, so they are
    // loaded on the grant and cleared as soon as ACCESS ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we_l       <= 1'b0;
            r_illegal    <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            r_locked     <= 1'b0;
`endif
            gnt          <= 2'b00;
            done         <= 2'b00;
            err          <= 1'b0;
            rdata        <= '0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_width    <= 3'd0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
                    r_locked <= 1'b0;
`endif
                    if (|req) begin
                        r_state      <= c_ST_ACCESS;
                        r_owner      <= w_win;
                        r_last_owner <= w_win;
                        r_we_l       <= w_sel_we;
                        r_illegal    <= w_sel_ill;
                        gnt          <= w_grant;
                        mem_re       <= ~w_sel_we & ~w_sel_ill;
                        mem_we       <=  w_sel_we & ~w_sel_ill;
                        mem_width    <= w_sel_width;
                        mem_addr     <= w_win ? addr1  : addr0;
                        mem_wdata    <= w_win ? wdata1 : wdata0;
                    end
                end
                c_ST_ACCESS: begin
                    r_state   <= c_ST_RESP;
                    gnt       <= 2'b00;
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_width <= 3'd0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    done      <= r_owner ? 2'b10 : 2'b01;
                    err       <= r_illegal;
                    rdata     <= (!r_we_l && !r_illegal) ? mem_rdata : '0;
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    done    <= 2'b00;
                    err     <= 1'b0;
                    rdata   <= '0;
`ifdef DMEM_ARB_LOCK_EN
                    r_locked <= lock[r_owner];
`endif
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    gnt     <= 2'b00;
                    done    <= 2'b00;
                    err     <= 1'b0;
                    rdata   <= '0;
                    mem_re  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Scoreboard bench for dmem_arbiter with a behavioural data
//                memory. The stimulus pushes the expected responses, and a
//                monitor pops and compares them on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_AW    = 8;
    localparam int c_DW    = 64;
    localparam int c_FIXED = 0;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req = '0;
    logic [1:0]      we = '0;
    logic [2:0]      width0 = '0, width1 = '0;
    logic [c_AW-1:0] addr0 = '0, addr1 = '0;
    logic [c_DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]      lock = '0;
    logic [1:0]      gnt, done;
    logic            err;
    logic [c_DW-1:0] rdata;
    logic            mem_re, mem_we;
    logic [2:0]      mem_width;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic [1:0]      done;
        logic            err;
        logic [c_DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [c_DW-1:0] mem [0:(1<<c_AW)-1];

    dmem_arbiter #(.FIXED_PRIO(c_FIXED), .AW(c_AW), .DW(c_DW)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .width0(width0), .width1(width1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .lock(lock),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [c_DW-1:0] wmask(input logic [2:0] w);
        case (w)
            3'd0:    return 64'h0000_0000_0000_00FF;
            3'd1:    return 64'h0000_0000_0000_FFFF;
            3'd2:    return 64'h0000_0000_FFFF_FFFF;
            3'd3:    return {c_DW{1'b1}};
            default: return '0;
        endcase
    endfunction

    // Behavioural memory: width-masked write at the clock edge, combinational read
    initial for (int i = 0; i < (1<<c_AW); i++) mem[i] = '0;
    always @(posedge clk)
        if (mem_we)
            mem[mem_addr] <= (mem[mem_addr] & ~wmask(mem_width)) | (mem_wdata & wmask(mem_width));
    assign mem_rdata = mem_re ? (mem[mem_addr] & wmask(mem_width)) : '0;

    task automatic check(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every done, plus memory-interface invariants
    always @(negedge clk) begin
        exp_t e;
        if (done != 2'b00) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=%b with empty scoreboard", done);
            end else begin
                e = sb.pop_front();
                check("sb_done",  {62'd0, done}, {62'd0, e.done});
                check("sb_err",   {63'd0, err},  {63'd0, e.err});
                check("sb_rdata", rdata, e.rdata);
            end
        end
        check("mem_re_we_exclusive", {63'd0, mem_re & mem_we}, 64'd0);
        if (gnt == 2'b00)
            check("mem_idle_zero", {55'd0, mem_re, mem_we, mem_width, mem_addr} | mem_wdata, 64'd0);
    end

    function automatic exp_t mk(input int port, input logic e, input logic [c_DW-1:0] rd);
        exp_t x;
        x.done  = (port == 1) ? 2'b10 : 2'b01;
        x.err   = e;
        x.rdata = rd;
        return x;
    endfunction

    // Single-port access with fixed latency checks (other port idle)
    task automatic access(input int port, input logic wr, input logic [2:0] w,
                          input logic [c_AW-1:0] a, input logic [c_DW-1:0] d,
                          input logic exp_err, input logic [c_DW-1:0] exp_rd);
        logic ill;
        logic [1:0] oh;
        ill = (w > 3'd3);
        oh  = (port == 1) ? 2'b10 : 2'b01;
        sb.push_back(mk(port, exp_err, exp_rd));
        @(posedge clk); #1;
        if (port == 1) begin we[1] = wr; width1 = w; addr1 = a; wdata1 = d; end
        else           begin we[0] = wr; width0 = w; addr0 = a; wdata0 = d; end
        req[port] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("acc_gnt",    {62'd0, gnt},    {62'd0, oh});
        check("acc_mem_we", {63'd0, mem_we}, {63'd0, wr & ~ill});
        check("acc_mem_re", {63'd0, mem_re}, {63'd0, ~wr & ~ill});
        check("acc_mem_addr",  {{(c_DW-c_AW){1'b0}}, mem_addr}, {{(c_DW-c_AW){1'b0}}, a});
        check("acc_mem_width", {61'd0, mem_width}, {61'd0, w});
        if (wr && !ill) check("acc_mem_wdata", mem_wdata, d);
        @(negedge clk);
        check("acc_done_latency", {62'd0, done}, {62'd0, oh});
        req[port] = 1'b0;
    endtask

    initial begin
        int k;
        int p1_phase;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {56'd0, gnt, done, err, mem_re, mem_we, 1'b0} | rdata | mem_wdata, 64'd0);
        rst = 1'b1;

        // 1: port 0 64-bit write, 2: port 1 32-bit read back
        access(0, 1'b1, 3'd3, 8'h10, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'd0);
        check("t1_mem", mem[8'h10], 64'hDEAD_BEEF_CAFE_F00D);
        access(1, 1'b0, 3'd2, 8'h10, 64'd0, 1'b0, 64'h0000_0000_CAFE_F00D);

        // 3: both ports held for four accesses
        we = 2'b00; width0 = 3'd3; addr0 = 8'h10; width1 = 3'd1; addr1 = 8'h10;
        for (int i = 0; i < 4; i++) begin
            if (c_FIXED != 0 || (i % 2) == 0) sb.push_back(mk(0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D));
            else                              sb.push_back(mk(1, 1'b0, 64'h0000_0000_0000_F00D));
        end
        @(posedge clk); #1; req = 2'b11;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (done != 2'b00) k++;
        end
        check("t3_count", k, 4);
        req = 2'b00;

        // 4: illegal width, no memory effect
        access(0, 1'b1, 3'd5, 8'h30, 64'h1111_2222_3333_4444, 1'b1, 64'd0);
        check("t4_mem", mem[8'h30], 64'd0);

        // 5: reset in the ACCESS cycle of a write
        we[0] = 1'b1; width0 = 3'd3; addr0 = 8'h20; wdata0 = 64'h1234;
        @(posedge clk); #1; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("t5_gnt", {62'd0, gnt}, 64'd1);
        rst = 1'b0;
        #1;
        check("t5_async_clear", {56'd0, gnt, done, err, mem_re, mem_we, 1'b0} | rdata | mem_wdata
                                | {{(c_DW-c_AW){1'b0}}, mem_addr}, 64'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("t5_mem", mem[8'h20], 64'd0);
        rst = 1'b1;
        we = 2'b00; width0 = 3'd2; addr0 = 8'h10; width1 = 3'd3; addr1 = 8'h10;
        sb.push_back(mk(0, 1'b0, 64'h0000_0000_CAFE_F00D));
        @(posedge clk); #1; req = 2'b11;
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 1; cyc++) begin
            @(negedge clk);
            if (done != 2'b00) k++;
        end
        check("t5_count", k, 1);
        req = 2'b00;

        // 6: port 1 read with lock, then a write, while port 0 keeps requesting
        we = 2'b00; width0 = 3'd0; addr0 = 8'h10; width1 = 3'd3; addr1 = 8'h10; lock = 2'b10;
        sb.push_back(mk(1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D));
`ifdef DMEM_ARB_LOCK_EN
        sb.push_back(mk(1, 1'b0, 64'd0));
        sb.push_back(mk(0, 1'b0, 64'h0000_0000_0000_00A5));
`else
        sb.push_back(mk(0, 1'b0, 64'h0000_0000_0000_000D));
        sb.push_back(mk(1, 1'b0, 64'd0));
`endif
        @(posedge clk); #1; req = 2'b11;
        k = 0;
        p1_phase = 0;
        for (int cyc = 0; cyc < 60 && k < 3; cyc++) begin
            @(negedge clk);
            if (gnt[1] && p1_phase == 1) lock[1] = 1'b0;
            if (done[1]) begin
                if (p1_phase == 0) begin
                    p1_phase = 1;
                    we[1]    = 1'b1;
                    wdata1   = 64'h0000_0000_0000_00A5;
                end else begin
                    req[1] = 1'b0;
                end
            end
            if (done[0]) req[0] = 1'b0;
            if (done != 2'b00) k++;
        end
        check("t6_count", k, 3);
        req = 2'b00; lock = 2'b00;
        repeat (3) @(negedge clk);
        check("t6_mem", mem[8'h10], 64'h0000_0000_0000_00A5);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
